// File: rtl/spawn_picker_pkg.sv
// Shared game constants for the spawn picker: grid defaults, coordinate widths,
// FSM state encoding and the cell payload carried on the occupancy/result bus.
package spawn_picker_pkg;

  localparam int unsigned GRID_W_DEF = 40;
  localparam int unsigned GRID_H_DEF = 30;
  localparam int unsigned X_W        = 6;
  localparam int unsigned Y_W        = 5;
  localparam int unsigned RAND_W     = 12;
  localparam int unsigned TRY_W      = 8;
  localparam int unsigned STATE_W    = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SAMPLE = 2'd1;
  localparam logic [STATE_W-1:0] ST_CHECK  = 2'd2;
  localparam logic [STATE_W-1:0] ST_FINISH = 2'd3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cell_t;

  // Column in the low bits, row above it; the LFSR's top bit is not used.
  function automatic cell_t rand_to_cell(input logic [X_W+Y_W-1:0] r);
    cell_t c;
    c.x = r[X_W-1:0];
    c.y = r[X_W+Y_W-1:X_W];
    return c;
  endfunction

endpackage

// File: rtl/spawn_picker_if.sv
// Request, occupancy-query and result signals between a game controller
// (master) and the spawn picker (slave).
interface spawn_picker_if;
  import spawn_picker_pkg::*;

  logic [RAND_W-1:0] rand_in;
  logic              req;
  logic              occ_rd;
  logic [X_W-1:0]    occ_x;
  logic [Y_W-1:0]    occ_y;
  logic              occ_hit;
  logic              busy;
  logic              done;
  logic              fail;
  logic [X_W-1:0]    pos_x;
  logic [Y_W-1:0]    pos_y;

  modport slave (
    input  rand_in, req, occ_hit,
    output occ_rd, occ_x, occ_y, busy, done, fail, pos_x, pos_y
  );

  modport master (
    output rand_in, req, occ_hit,
    input  occ_rd, occ_x, occ_y, busy, done, fail, pos_x, pos_y
  );
endinterface

// File: rtl/spawn_picker.sv
// Picks a random free grid cell: samples the LFSR, rejects off-grid or occupied
// cells, and gives up after MAX_TRIES rejections.
module spawn_picker
  import spawn_picker_pkg::*;
#(
  parameter int unsigned GRID_W    = GRID_W_DEF,
  parameter int unsigned GRID_H    = GRID_H_DEF,
  parameter int unsigned MAX_TRIES = 64
) (
  input  logic           clk,
  input  logic           rst,
  spawn_picker_if.slave  bus
);

  // One extra bit so a full-width grid (64 or 32) still compares correctly.
  localparam logic [X_W:0]       GRID_W_L    = (X_W+1)'(GRID_W);
  localparam logic [Y_W:0]       GRID_H_L    = (Y_W+1)'(GRID_H);
  localparam logic [TRY_W-1:0]   MAX_TRIES_L = TRY_W'(MAX_TRIES);

  logic [STATE_W-1:0] r_state;
  logic [TRY_W-1:0]   r_tries;
  cell_t              r_cand;
  cell_t              r_pos;
  logic               r_fail;
  logic               r_done;
  logic               r_busy;

  logic [STATE_W-1:0] w_state_nxt;
  logic [TRY_W-1:0]   w_tries_nxt;
  cell_t              w_cand_nxt;
  cell_t              w_pos_nxt;
  logic               w_fail_nxt;
  logic               w_done_nxt;

  cell_t              w_sample;
  logic               w_in_range;
  logic [TRY_W-1:0]   w_tries_inc;
  logic               w_exhaust;
  logic               w_unused_msb;

  assign w_sample     = rand_to_cell(bus.rand_in[X_W+Y_W-1:0]);
  assign w_unused_msb = bus.rand_in[RAND_W-1];
  assign w_in_range   = ({1'b0, w_sample.x} < GRID_W_L) && ({1'b0, w_sample.y} < GRID_H_L);
  assign w_tries_inc  = r_tries + TRY_W'(1);
  assign w_exhaust    = (w_tries_inc == MAX_TRIES_L);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tries <= '0;
      r_cand  <= '0;
      r_pos   <= '0;
      r_fail  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tries <= w_tries_nxt;
      r_cand  <= w_cand_nxt;
      r_pos   <= w_pos_nxt;
      r_fail  <= w_fail_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_tries_nxt = r_tries;
    w_cand_nxt  = r_cand;
    w_pos_nxt   = r_pos;
    w_fail_nxt  = r_fail;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_tries_nxt = '0;
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (w_in_range) begin
          w_cand_nxt  = w_sample;
          w_state_nxt = ST_CHECK;
        end else begin
          w_tries_nxt = w_tries_inc;
          if (w_exhaust) begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_CHECK: begin
        if (bus.occ_hit) begin
          w_tries_nxt = w_tries_inc;
          if (w_exhaust) begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_SAMPLE;
          end
        end else begin
          w_pos_nxt   = r_cand;
          w_fail_nxt  = 1'b0;
          w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The query strobe is combinational so the answer arrives in CHECK.
  assign bus.occ_rd = (r_state == ST_SAMPLE) && w_in_range;
  assign bus.occ_x  = w_sample.x;
  assign bus.occ_y  = w_sample.y;

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.fail  = r_fail;
  assign bus.pos_x = r_pos.x;
  assign bus.pos_y = r_pos.y;

endmodule
